// File: rtl/stack_arb_pkg.sv
// Shared constants for the stack arbiter: FSM encoding, op encoding and default widths.
package stack_arb_pkg;

  localparam int unsigned DefDataWide     = 8;
  localparam int unsigned DefAddressDepth = 4;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     rr_ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     gnt_id_o
);

  logic           found;
  logic [IdW-1:0] cand;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    cand     = '0;
    if (en_i) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = IdW'((32'(rr_ptr_i) + off) % NUM_REQ);
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_o[cand] = 1'b1;
          gnt_id_o    = cand;
        end
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one FILO stack between NUM_REQ requesters, one op at a time, round-robin order.
// Illegal ops (push when full, pop when empty) are answered with an error and never issued.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int unsigned AddressDepth = DefAddressDepth,
  parameter int unsigned DataWide     = DefDataWide,
  parameter int unsigned NUM_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*DataWide-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DataWide-1:0]         rsp_data,
  output logic                        rsp_err,
  output logic                        stk_cs,
  output logic                        stk_push_pop,
  output logic [DataWide-1:0]         stk_data_in,
  input  logic [DataWide-1:0]         stk_data_out,
  input  logic                        stk_full,
  input  logic                        stk_empty
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (AddressDepth < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
    $error("stack_arbiter: unsupported AddressDepth/NUM_REQ");
  end

  logic [1:0]          state_q, state_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]      id_q, id_d;
  logic                op_q, op_d;
  logic                err_q, err_d;
  logic [DataWide-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IdW-1:0]      gnt_id;
  logic                arb_en;
  logic                sel_op;
  logic [DataWide-1:0] sel_data;
  logic                illegal;
  logic                in_resp;

  // Grants are suppressed while rst is high so nothing is accepted during reset.
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req_ready = gnt;
  assign sel_op    = req_op[gnt_id];
  assign sel_data  = req_data[32'(gnt_id) * DataWide +: DataWide];
  assign illegal   = (sel_op == OP_PUSH) ? stk_full : stk_empty;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    err_d    = err_q;
    data_d   = data_q;
    case (state_q)
      StIdle: begin
        if (|gnt) begin
          id_d     = gnt_id;
          op_d     = sel_op;
          data_d   = (sel_op == OP_PUSH) ? sel_data : '0;
          err_d    = illegal;
          rr_ptr_d = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d  = illegal ? StResp : StIssue;
        end
      end
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  // Stack outputs come straight from registered state; data_q is already 0 for pops.
  assign stk_cs       = (state_q == StIssue);
  assign stk_push_pop = stk_cs & op_q;
  assign stk_data_in  = stk_cs ? data_q : '0;

  assign in_resp  = (state_q == StResp);
  assign rsp_err  = in_resp & err_q;
  assign rsp_data = (in_resp && !err_q && op_q == OP_POP) ? stk_data_out : '0;

  always_comb begin
    rsp_valid = '0;
    if (in_resp) rsp_valid[id_q] = 1'b1;
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomised self-checking bench for stack_arbiter with a behavioural FILO stack and a
// queue-based reference model of the expected responses and round-robin order.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int unsigned NR  = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned AD  = 4;
  localparam int unsigned CAP = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_op, req_ready, rsp_valid;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    rsp_data, stk_data_in, stk_data_out;
  logic             rsp_err, stk_cs, stk_push_pop, stk_full, stk_empty;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cs_total = 0;

  logic [DW-1:0] ref_q[$];
  int            ref_ptr = 0;

  always #5 clk = ~clk;

  stack_arbiter #(
    .AddressDepth (AD),
    .DataWide     (DW),
    .NUM_REQ      (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_cs       (stk_cs),
    .stk_push_pop (stk_push_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty)
  );

  // Behavioural FILO stack: executes on the edge where CS is high.
  logic [DW-1:0] smem [CAP];
  int            sp = 0;
  logic [DW-1:0] sdout = '0;
  assign stk_full     = (sp == CAP);
  assign stk_empty    = (sp == 0);
  assign stk_data_out = sdout;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_cs) begin
      cs_total <= cs_total + 1;
      if (stk_push_pop && sp < CAP) begin
        smem[sp] <= stk_data_in;
        sp       <= sp + 1;
      end else if (!stk_push_pop && sp > 0) begin
        sdout <= smem[sp-1];
        sp    <= sp - 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1);
  end

  // Reference model: expected response for one op, updating the reference LIFO.
  task automatic model_op(input int id, input logic op, input logic [DW-1:0] d,
                          output logic [NR-1:0] e_rv, output logic e_er,
                          output logic [DW-1:0] e_rd, output int e_lat, output int e_cs);
    e_rv     = '0;
    e_rv[id] = 1'b1;
    e_rd     = '0;
    e_er     = op ? (ref_q.size() == CAP) : (ref_q.size() == 0);
    if (!e_er) begin
      if (op) ref_q.push_back(d);
      else    e_rd = ref_q.pop_back();
    end
    e_lat = e_er ? 1 : 2;
    e_cs  = e_er ? 0 : 1;
  endtask

  // Drives one request and returns what the DUT did; starts and ends just after a negedge.
  task automatic drive_op(input int id, input logic op, input logic [DW-1:0] d,
                          output logic tmo, output logic [NR-1:0] rdy, output int acc,
                          output int lat, output logic [NR-1:0] rv, output logic er,
                          output logic [DW-1:0] rd, output int cs_n);
    int n = 0;
    int cs0;
    tmo = 1'b0; rdy = '0; acc = 0; lat = 0; rv = '0; er = 1'b0; rd = '0; cs_n = 0;
    @(posedge clk); #1;
    req_valid[id]         = 1'b1;
    req_op[id]            = op;
    req_data[id*DW +: DW] = d;
    @(negedge clk);
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[id]) begin
      tmo = 1'b1;
      req_valid[id] = 1'b0;
      return;
    end
    rdy = req_ready;
    acc = cyc;
    cs0 = cs_total;
    ref_ptr = (id + 1) % NR;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (rsp_valid == '0 && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid == '0) tmo = 1'b1;
    rv   = rsp_valid;
    er   = rsp_err;
    rd   = rsp_data;
    cs_n = cs_total - cs0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_op = '0;
    req_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_data, stk_cs, stk_push_pop, stk_data_in} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b rv=%b err=%b rd=%h cs=%b pp=%b din=%h, want all 0",
                 i, req_ready, rsp_valid, rsp_err, rsp_data, stk_cs, stk_push_pop, stk_data_in);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    ref_ptr = 0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, stk_cs} !== '0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got rdy=%b rv=%b cs=%b, want 0", req_ready, rsp_valid, stk_cs);
    end
  endtask

  task automatic test_pop_empty();
    logic tmo, er; logic [NR-1:0] rdy, rv; logic [DW-1:0] rd; int acc, lat, cs_n;
    logic [NR-1:0] e_rv; logic e_er; logic [DW-1:0] e_rd; int e_lat, e_cs;
    model_op(0, OP_POP, '0, e_rv, e_er, e_rd, e_lat, e_cs);
    drive_op(0, OP_POP, '0, tmo, rdy, acc, lat, rv, er, rd, cs_n);
    n_checks++;
    if (tmo || {rdy, rv, er, rd} !== {2'b01, e_rv, e_er, e_rd}) begin
      n_errors++;
      $display("FAIL pop_empty: got tmo=%b rdy=%b rv=%b err=%b rd=%h, want rdy=01 rv=%b err=%b rd=%h",
               tmo, rdy, rv, er, rd, e_rv, e_er, e_rd);
    end
    n_checks++;
    if (lat != e_lat || cs_n != e_cs) begin
      n_errors++;
      $display("FAIL pop_empty_timing: got lat=%0d cs=%0d, want lat=%0d cs=%0d", lat, cs_n, e_lat, e_cs);
    end
  endtask

  // Sequence of single-requester ops: fill/overflow (push) or drain/underflow (pop).
  task automatic test_sequence(input string name, input int id, input logic op);
    logic tmo, er; logic [NR-1:0] rdy, rv; logic [DW-1:0] rd, d; int acc, lat, cs_n;
    logic [NR-1:0] e_rv; logic e_er; logic [DW-1:0] e_rd; int e_lat, e_cs;
    int prev_acc = 0;
    logic [NR-1:0] e_rdy;
    for (int i = 0; i <= int'(CAP); i++) begin
      d = op ? DW'(i) : '0;
      e_rdy = '0;
      e_rdy[id] = 1'b1;
      model_op(id, op, d, e_rv, e_er, e_rd, e_lat, e_cs);
      drive_op(id, op, d, tmo, rdy, acc, lat, rv, er, rd, cs_n);
      n_checks++;
      if (tmo || {rdy, rv, er, rd} !== {e_rdy, e_rv, e_er, e_rd}) begin
        n_errors++;
        $display("FAIL %s[%0d]: got tmo=%b rdy=%b rv=%b err=%b rd=%h, want rdy=%b rv=%b err=%b rd=%h",
                 name, i, tmo, rdy, rv, er, rd, e_rdy, e_rv, e_er, e_rd);
      end
      n_checks++;
      if (lat != e_lat || cs_n != e_cs || (i > 0 && acc - prev_acc != 3)) begin
        n_errors++;
        $display("FAIL %s_timing[%0d]: got lat=%0d cs=%0d spacing=%0d, want lat=%0d cs=%0d spacing=3",
                 name, i, lat, cs_n, acc - prev_acc, e_lat, e_cs);
      end
      prev_acc = acc;
    end
  endtask

  task automatic test_fairness();
    logic tmo, er; logic [NR-1:0] rdy, rv; logic [DW-1:0] rd; int acc, lat, cs_n;
    logic [NR-1:0] e_rv; logic e_er; logic [DW-1:0] e_rd; int e_lat, e_cs;
    logic [NR-1:0] e_rdy;
    int prev = 0;
    int n;
    int g;
    @(posedge clk); #1;
    req_op    = 2'b11;
    req_data  = {8'hB0, 8'hA0};
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      g = -1;
      for (int o = 0; o < int'(NR); o++) begin
        int c = (ref_ptr + o) % NR;
        if (g < 0 && req_valid[c]) g = c;
      end
      e_rdy = '0;
      e_rdy[g] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (req_ready !== e_rdy || (k > 0 && cyc - prev != 3)) begin
        n_errors++;
        $display("FAIL fairness_grant[%0d]: got rdy=%b spacing=%0d, want rdy=%b spacing=3",
                 k, req_ready, cyc - prev, e_rdy);
      end
      prev = cyc;
      ref_q.push_back(g == 0 ? 8'hA0 : 8'hB0);
      ref_ptr = (g + 1) % NR;
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      model_op(0, OP_POP, '0, e_rv, e_er, e_rd, e_lat, e_cs);
      drive_op(0, OP_POP, '0, tmo, rdy, acc, lat, rv, er, rd, cs_n);
      n_checks++;
      if (tmo || {rv, er, rd} !== {e_rv, e_er, e_rd}) begin
        n_errors++;
        $display("FAIL fairness_pop[%0d]: got tmo=%b rv=%b err=%b rd=%h, want rv=%b err=%b rd=%h",
                 k, tmo, rv, er, rd, e_rv, e_er, e_rd);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_op[1]    = OP_PUSH;
    req_data[DW +: DW] = 8'h55;
    @(negedge clk);
    while (!req_ready[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({stk_cs, stk_push_pop, stk_data_in} !== {1'b1, 1'b1, 8'h55}) begin
      n_errors++;
      $display("FAIL mid_reset_issue: got cs=%b pp=%b din=%h, want cs=1 pp=1 din=55",
               stk_cs, stk_push_pop, stk_data_in);
    end
    ref_q.push_back(8'h55);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    req_valid[0] = 1'b1;
    req_op[0]    = OP_POP;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== '0 || req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL mid_reset_idle: got rv=%b rdy=%b, want rv=00 rdy=01", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_dropped: got rv=%b, want 00", rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, ref_q.pop_back()}) begin
      n_errors++;
      $display("FAIL mid_reset_pop: got rv=%b err=%b rd=%h, want rv=01 err=0 rd=55",
               rsp_valid, rsp_err, rsp_data);
    end
    ref_ptr = 1;
  endtask

  task automatic test_random();
    logic tmo, er; logic [NR-1:0] rdy, rv; logic [DW-1:0] rd, d; int acc, lat, cs_n;
    logic [NR-1:0] e_rv; logic e_er; logic [DW-1:0] e_rd; int e_lat, e_cs;
    int id, prev_acc, prev_lat;
    logic op;
    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 60; i++) begin
      id = int'($urandom_range(NR - 1, 0));
      op = (i < 30) ? ($urandom_range(99, 0) < 80) : ($urandom_range(99, 0) < 20);
      d  = DW'($urandom);
      model_op(id, op, d, e_rv, e_er, e_rd, e_lat, e_cs);
      drive_op(id, op, d, tmo, rdy, acc, lat, rv, er, rd, cs_n);
      n_checks++;
      if (tmo || {rdy, rv, er, rd} !== {e_rv, e_rv, e_er, e_rd}) begin
        n_errors++;
        $display("FAIL random[%0d] id=%0d op=%b: got tmo=%b rdy=%b rv=%b err=%b rd=%h, want rdy=%b rv=%b err=%b rd=%h",
                 i, id, op, tmo, rdy, rv, er, rd, e_rv, e_rv, e_er, e_rd);
      end
      n_checks++;
      if (lat != e_lat || cs_n != e_cs || (i > 0 && acc - prev_acc != prev_lat + 1)) begin
        n_errors++;
        $display("FAIL random_timing[%0d]: got lat=%0d cs=%0d spacing=%0d, want lat=%0d cs=%0d spacing=%0d",
                 i, lat, cs_n, acc - prev_acc, e_lat, e_cs, prev_lat + 1);
      end
      prev_acc = acc;
      prev_lat = e_lat;
    end
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_sequence("fill", 1, OP_PUSH);
    test_sequence("lifo", 0, OP_POP);
    test_fairness();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
